// File: rtl/btn_pkg.sv
// ============================================================================
// btn_pkg : shared types and counter-width helper for the button conditioner
// Rev 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } btn_state_t;

    // One spare bit so a counter can always hold its terminal value.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_chan.sv
// ============================================================================
// btn_debounce_chan : one button channel - synchroniser, debounce FSM,
//                     optional auto-repeat, registered level/pulse outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int C_CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam int C_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_RW      = cnt_width(C_REP_MAX);
    localparam bit C_REP_EN  = (REPEAT_DELAY > 0);

    localparam logic [C_CW-1:0] C_DB_LAST  = C_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_RW-1:0] C_DLY_LAST = C_REP_EN ? C_RW'(REPEAT_DELAY - 1) : '0;
    localparam logic [C_RW-1:0] C_PER_LAST = (REPEAT_PERIOD > 0) ? C_RW'(REPEAT_PERIOD - 1) : '0;

    logic            r_sync1;
    logic            r_sync2;
    btn_state_t      r_state;
    btn_state_t      w_state_nxt;
    logic [C_CW-1:0] r_cnt;
    logic [C_CW-1:0] w_cnt_nxt;
    logic [C_RW-1:0] r_rep;
    logic [C_RW-1:0] w_rep_nxt;
    logic            r_periodic;
    logic            w_periodic_nxt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            w_s;
    logic            w_db_done;
    logic            w_rep_hit;
    logic            w_level_d;
    logic            w_press_d;
    logic            w_release_d;

    assign w_s       = r_sync2;
    assign w_db_done = (r_cnt == C_DB_LAST);
    assign w_rep_hit = C_REP_EN && (r_state == ST_HELD) && w_s &&
                       (r_periodic ? (r_rep == C_PER_LAST) : (r_rep == C_DLY_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rep      <= '0;
            r_periodic <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rep      <= w_rep_nxt;
            r_periodic <= w_periodic_nxt;
            r_level    <= w_level_d;
            r_press    <= w_press_d;
            r_release  <= w_release_d;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rep_nxt      = r_rep;
        w_periodic_nxt = r_periodic;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_PRESS_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_db_done) begin
                    w_state_nxt    = ST_HELD;
                    w_rep_nxt      = '0;
                    w_periodic_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CW'(1);
                end
            end
            ST_HELD: begin
                // A falling sample wins over a due repeat, so the two never overlap.
                if (!w_s) begin
                    w_state_nxt    = ST_RELEASE_CHK;
                    w_cnt_nxt      = '0;
                    w_rep_nxt      = '0;
                    w_periodic_nxt = 1'b0;
                end else if (C_REP_EN) begin
                    if (w_rep_hit) begin
                        w_rep_nxt      = '0;
                        w_periodic_nxt = 1'b1;
                    end else begin
                        w_rep_nxt = r_rep + C_RW'(1);
                    end
                end
            end
            ST_RELEASE_CHK: begin
                if (w_s) begin
                    w_state_nxt    = ST_HELD;
                    w_rep_nxt      = '0;
                    w_periodic_nxt = 1'b0;
                end else if (w_db_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_level_d   = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_CHK);
        w_press_d   = ((r_state == ST_PRESS_CHK) && w_s && w_db_done) || w_rep_hit;
        w_release_d = (r_state == ST_RELEASE_CHK) && !w_s && w_db_done;
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

`default_nettype wire

// File: rtl/btn_debouncer.sv
// ============================================================================
// btn_debouncer : N_BTN independent debounced button channels plus any_held
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debouncer
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_held
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[gi]),
            .btn_level   (btn_level[gi]),
            .btn_press   (btn_press[gi]),
            .btn_release (btn_release[gi])
        );
    end

    // Levels are flop outputs, so this OR has no path from btn_raw.
    assign any_held = |btn_level;

endmodule

`default_nettype wire

// File: tb/tb_btn_debouncer.sv
// ============================================================================
// tb_btn_debouncer : directed checks of debounce, glitch, repeat and reset
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_btn_debouncer;

    logic       clk;
    logic       rst_n;
    logic [1:0] raw_a, level_a, press_a, release_a;
    logic       held_a;
    logic [1:0] raw_b, level_b, press_b, release_b;
    logic       held_b;

    int checks   = 0;
    int failures = 0;

    btn_debouncer #(
        .N_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_a), .btn_level(level_a),
        .btn_press(press_a), .btn_release(release_a), .any_held(held_a)
    );

    btn_debouncer #(
        .N_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut_rep (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_b), .btn_level(level_b),
        .btn_press(press_b), .btn_release(release_b), .any_held(held_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw_a = 2'b00;
        raw_b = 2'b00;
        repeat (3) tick();
        checks++; if (level_a !== 2'b00)   begin failures++; $display("FAIL reset_level_a got=%b exp=00", level_a); end
        checks++; if (press_a !== 2'b00)   begin failures++; $display("FAIL reset_press_a got=%b exp=00", press_a); end
        checks++; if (release_a !== 2'b00) begin failures++; $display("FAIL reset_release_a got=%b exp=00", release_a); end
        checks++; if (held_a !== 1'b0)     begin failures++; $display("FAIL reset_held_a got=%b exp=0", held_a); end
        checks++; if (level_b !== 2'b00 || press_b !== 2'b00 || release_b !== 2'b00 || held_b !== 1'b0) begin
            failures++; $display("FAIL reset_rep_outputs got=%b%b%b%b exp=0000000", level_b, press_b, release_b, held_b);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_clean_press();
        raw_a = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (press_a !== ((i == 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL clean_press tick=%0d got=%b", i, press_a); end
            checks++; if (level_a !== ((i >= 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL clean_level tick=%0d got=%b", i, level_a); end
            checks++; if (release_a !== 2'b00) begin failures++; $display("FAIL clean_release tick=%0d got=%b exp=00", i, release_a); end
            checks++; if (held_a !== (i >= 7)) begin failures++; $display("FAIL clean_any_held tick=%0d got=%b exp=%b", i, held_a, (i >= 7)); end
        end
    endtask

    task automatic test_release_blip();
        raw_a[0] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++; if (release_a !== ((i == 12) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL blip_release tick=%0d got=%b", i, release_a); end
            checks++; if (level_a !== ((i < 12) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL blip_level tick=%0d got=%b", i, level_a); end
            checks++; if (press_a !== 2'b00) begin failures++; $display("FAIL blip_press tick=%0d got=%b exp=00", i, press_a); end
            if (i == 3) raw_a[0] = 1'b1;
            if (i == 5) raw_a[0] = 1'b0;
        end
    endtask

    task automatic test_bounce();
        int npress = 0;
        for (int i = 0; i < 20; i++) begin
            raw_a[0] = (i < 8) ? ((i % 2) == 0) : 1'b1;
            tick();
            if (press_a[0] === 1'b1) npress++;
            checks++; if (press_a !== ((i + 1 == 15) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL bounce_press tick=%0d got=%b", i + 1, press_a); end
            checks++; if (release_a !== 2'b00) begin failures++; $display("FAIL bounce_release tick=%0d got=%b exp=00", i + 1, release_a); end
        end
        checks++; if (npress != 1) begin failures++; $display("FAIL bounce_press_count got=%0d exp=1", npress); end
    endtask

    task automatic test_release();
        raw_a[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (release_a !== ((i == 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL release_pulse tick=%0d got=%b", i, release_a); end
            checks++; if (level_a !== ((i < 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL release_level tick=%0d got=%b", i, level_a); end
        end
    endtask

    task automatic test_glitch();
        raw_a[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++; if (press_a !== 2'b00 || level_a !== 2'b00 || release_a !== 2'b00) begin
                failures++; $display("FAIL glitch tick=%0d got press=%b level=%b release=%b exp all 00", i, press_a, level_a, release_a);
            end
            if (i == 3) raw_a[1] = 1'b0;
        end
    endtask

    task automatic test_repeat();
        logic [1:0] ep;
        raw_b = 2'b01;
        for (int i = 1; i <= 36; i++) begin
            tick();
            ep = (i == 7 || i == 15 || i == 18 || i == 21 || i == 24) ? 2'b01 : 2'b00;
            checks++; if (press_b !== ep) begin failures++; $display("FAIL repeat_press tick=%0d got=%b exp=%b", i, press_b, ep); end
            checks++; if (release_b !== ((i == 31) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL repeat_release tick=%0d got=%b", i, release_b); end
            checks++; if (level_b !== ((i >= 7 && i < 31) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL repeat_level tick=%0d got=%b", i, level_b); end
            if (i == 24) raw_b[0] = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        raw_a = 2'b01;
        repeat (5) tick();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (press_a !== 2'b00 || level_a !== 2'b00 || release_a !== 2'b00 || held_a !== 1'b0) begin
            failures++; $display("FAIL arst_pchk got press=%b level=%b release=%b held=%b exp all 0", press_a, level_a, release_a, held_a);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++; if (press_a !== ((i == 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL arst_repress1 tick=%0d got=%b", i, press_a); end
        end
        checks++; if (level_a !== 2'b01) begin failures++; $display("FAIL arst_held_before got=%b exp=01", level_a); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (level_a !== 2'b00) begin failures++; $display("FAIL arst_held_level got=%b exp=00", level_a); end
        checks++; if (held_a !== 1'b0)   begin failures++; $display("FAIL arst_held_any got=%b exp=0", held_a); end
        checks++; if (press_a !== 2'b00 || release_a !== 2'b00) begin failures++; $display("FAIL arst_held_pulses got=%b%b exp=0000", press_a, release_a); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++; if (press_a !== ((i == 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL arst_repress2 tick=%0d got=%b", i, press_a); end
            checks++; if (level_a !== ((i >= 7) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL arst_relevel tick=%0d got=%b", i, level_a); end
        end
        raw_a = 2'b00;
        repeat (10) tick();
    endtask

    task automatic test_simultaneous();
        raw_a = 2'b11;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++; if (press_a !== ((i == 7) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL simul_press tick=%0d got=%b", i, press_a); end
            checks++; if (held_a !== (i >= 7)) begin failures++; $display("FAIL simul_any_held tick=%0d got=%b exp=%b", i, held_a, (i >= 7)); end
        end
        raw_a = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++; if (release_a !== ((i == 7) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL simul_release tick=%0d got=%b", i, release_a); end
            checks++; if (held_a !== (i < 7)) begin failures++; $display("FAIL simul_any_clear tick=%0d got=%b exp=%b", i, held_a, (i < 7)); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_blip();
        test_bounce();
        test_release();
        test_glitch();
        test_repeat();
        test_async_reset();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
